// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// in 33 cycles (32 iterations + sign fix-up) and serves MFHI/MFLO/MTHI/MTLO.
module ex_mdu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            valid_in,
    input  logic [3:0]      md_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            stall_out,
    output logic            busy,
    output logic [XLEN-1:0] result_out,
    output logic            res_valid,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     raw_rs_q, raw_rs_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                dz_q, dz_d;
    logic                is_div_q, is_div_d;

    logic                md, accept, is_signed, rs_neg, rt_neg, qbit;
    logic [XLEN-1:0]     rs_mag, rt_mag, quo_fix, rem_fix;
    logic [XLEN:0]       msum, trial, diff;
    logic [2*XLEN-1:0]   prod_fix;

    always_comb begin
        md        = valid_in && !flush && (md_op >= 4'd1) && (md_op <= 4'd8);
        busy      = (state_q != S_IDLE);
        stall_out = md && busy;
        accept    = md && !busy;

        is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
        rs_neg    = is_signed && rs_val[XLEN-1];
        rt_neg    = is_signed && rt_val[XLEN-1];
        rs_mag    = rs_neg ? -rs_val : rs_val;
        rt_mag    = rt_neg ? -rt_val : rt_val;

        // Multiply: add multiplicand into the upper half when the low multiplier bit is set,
        // then shift the whole 64-bit accumulator right; the multiplier drains out of the bottom.
        msum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);

        // Divide: dividend bits shift out of acc_q[XLEN-1:0] as quotient bits shift in.
        trial = {rem_q, acc_q[XLEN-1]};
        diff  = trial - {1'b0, b_q};
        qbit  = !diff[XLEN];

        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quo_fix  = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_hi_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        raw_rs_d = raw_rs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        result_out = '0;
        res_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_MUL;
                            is_div_d = 1'b0;
                            a_d      = rs_mag;
                            acc_d    = {{XLEN{1'b0}}, rt_mag};
                            neg_lo_d = rs_neg ^ rt_neg;
                            neg_hi_d = rs_neg ^ rt_neg;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_DIV;
                            is_div_d = 1'b1;
                            b_d      = rt_mag;
                            acc_d    = {{XLEN{1'b0}}, rs_mag};
                            rem_d    = '0;
                            neg_lo_d = rs_neg ^ rt_neg;
                            neg_hi_d = rs_neg;
                        end
                        OP_MFHI: begin
                            result_out = hi_q;
                            res_valid  = 1'b1;
                        end
                        OP_MFLO: begin
                            result_out = lo_q;
                            res_valid  = 1'b1;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                    if (md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
                        cnt_d    = '0;
                        raw_rs_d = rs_val;
                        dz_d     = (rt_val == '0);
                    end
                end
            end
            S_MUL: begin
                acc_d = {msum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_FIX;
            end
            S_DIV: begin
                rem_d = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
                acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end else if (dz_q) begin
                    hi_d = raw_rs_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            raw_rs_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            raw_rs_q <= raw_rs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed corner cases plus randomized MDU ops
// compared against a plain-arithmetic HI/LO model.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall_out;
    logic        busy;
    logic [31:0] result_out;
    logic        res_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_tests = 0;
    int n_fail  = 0;

    ex_mdu #(.XLEN(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .valid_in   (valid_in),
        .md_op      (md_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .stall_out  (stall_out),
        .busy       (busy),
        .result_out (result_out),
        .res_valid  (res_valid),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO straight from integer arithmetic and the special-case rules.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        hi = '0;
        lo = '0;
        case (op)
            4'd1: begin
                sp = longint'(sa) * longint'(sb);
                hi = sp[63:32];
                lo = sp[31:0];
            end
            4'd2: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            4'd3, 4'd4: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == 4'd4) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: ;
        endcase
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic fl);
        @(posedge clk); #1;
        valid_in = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        flush    = fl;
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        valid_in = 1'b0;
        md_op    = 4'd0;
        flush    = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_out) n++;
            else break;
        end
    endtask

    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        int n;
        model(op, a, b, ehi, elo);
        present(op, a, b, 1'b0);
        @(negedge clk);
        check({tag, "_issue_stall"}, 64'(stall_out), 64'd0);
        idle_in();
        wait_busy(n);
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_hi"}, 64'(hi_out), 64'(ehi));
        check({tag, "_lo"}, 64'(lo_out), 64'(elo));
        present(4'd5, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check({tag, "_mfhi"}, {31'd0, res_valid, result_out}, {32'd1, ehi});
        present(4'd6, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check({tag, "_mflo"}, {31'd0, res_valid, result_out}, {32'd1, elo});
        idle_in();
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; md_op = 4'd0;
        rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        valid_in = 1'b1; md_op = 4'd10;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall_nonmd", 64'(stall_out), 64'd0);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_res_valid", 64'(res_valid), 64'd0);

        present(4'd7, 32'h1234, 32'd0, 1'b1);
        @(negedge clk);
        check("flushed_mthi_res_valid", 64'(res_valid), 64'd0);
        idle_in();
        @(negedge clk);
        check("flushed_mthi_hi", 64'(hi_out), 64'd0);
        present(4'd7, 32'h1234, 32'd0, 1'b0);
        idle_in();
        @(negedge clk);
        check("mthi_hi", 64'(hi_out), 64'h1234);
        present(4'd8, 32'h5678, 32'd0, 1'b0);
        idle_in();
        @(negedge clk);
        check("mtlo_lo", {hi_out, lo_out}, {32'h1234, 32'h5678});

        run_md("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("mult_m3x7", 4'd1, 32'hFFFF_FFFD, 32'd7);
        run_md("div_m7d2", 4'd3, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_5d0", 4'd4, 32'd5, 32'd0);
        run_md("div_m5d0", 4'd3, 32'hFFFF_FFFB, 32'd0);
        run_md("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_7dm2", 4'd3, 32'd7, 32'hFFFF_FFFE);

        present(4'd1, 32'd6, 32'd7, 1'b0);
        @(posedge clk); #1;
        md_op = 4'd6;
        wait_stall(n);
        check("mflo_b2b_stall_cycles", 64'(n), 64'd33);
        check("mflo_b2b_result", {31'd0, res_valid, result_out}, {32'd1, 32'h2A});
        idle_in();

        present(4'd2, 32'd3, 32'd4, 1'b0);
        @(posedge clk); #1;
        md_op = 4'd7; rs_val = 32'hABCD;
        wait_stall(n);
        check("mthi_vs_fix_stall_cycles", 64'(n), 64'd33);
        idle_in();
        @(negedge clk);
        check("mthi_vs_fix_hilo", {hi_out, lo_out}, {32'hABCD, 32'd12});

        present(4'd4, 32'd100, 32'd7, 1'b0);
        idle_in();
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_in = 1'b1; md_op = 4'd5;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_stall", 64'(stall_out), 64'd0);
        check("midrst_hilo", {hi_out, lo_out}, 64'd0);
        idle_in();
        run_md("post_rst_multu", 4'd2, 32'd3, 32'd4);

        for (int i = 0; i < 50; i++) begin
            rop = 4'($urandom_range(1, 4));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(0, 1000); rb = $urandom_range(0, 20); end
                2: begin ra = -32'($urandom_range(0, 1000)); rb = $urandom; end
                default: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                    rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd0;
                end
            endcase
            run_md($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
